// File: rtl/led_effect_engine.sv
// N-LED pattern generator with a tick prescaler and blink/fill/bounce/accumulate modes.
// A change of mode or speed restarts cleanly, and step_tick pulses for one cycle after each pattern advance.
module led_effect_engine #(
  parameter int N_LEDS   = 8,
  parameter int BASE_DIV = 4,
  parameter int DIV_W    = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        speed,
  input  logic [1:0]        mode,
  input  logic              run,
  output logic [N_LEDS-1:0] q_out,
  output logic              step_tick
);

  localparam int KW = $clog2(N_LEDS + 1);
  localparam int PW = $clog2(N_LEDS);
  localparam logic [N_LEDS-1:0] ALL_ONES = '1;
  localparam logic [N_LEDS-1:0] ONE_HOT0 = N_LEDS'(1);
  localparam logic [KW-1:0]     K_FULL   = KW'(N_LEDS);
  localparam logic [PW-1:0]     P_TOP    = PW'(N_LEDS - 1);

  typedef enum logic [1:0] {
    M_BLINK  = 2'd0,
    M_FILL   = 2'd1,
    M_BOUNCE = 2'd2,
    M_ACCUM  = 2'd3
  } mode_e;

  logic [DIV_W-1:0]  r_cnt;
  mode_e             r_mode_q;
  logic [1:0]        r_speed_q;
  logic [N_LEDS-1:0] r_q;
  logic              r_step;
  logic [PW-1:0]     r_pos;
  logic              r_dir;
  logic [KW-1:0]     r_k;
  logic [PW-1:0]     r_p;

  mode_e             w_mode;
  logic [DIV_W-1:0]  w_term;
  logic              w_mode_chg;
  logic              w_spd_chg;
  logic              w_tick;
  logic [N_LEDS-1:0] w_start_q;
  logic [N_LEDS-1:0] w_nxt_q;
  logic [PW-1:0]     w_nxt_pos;
  logic              w_nxt_dir;
  logic [KW-1:0]     w_nxt_k;
  logic [PW-1:0]     w_nxt_p;

  assign w_mode     = mode_e'(mode);
  assign w_term     = (DIV_W'(BASE_DIV) << r_speed_q) - DIV_W'(1);
  assign w_mode_chg = (w_mode != r_mode_q);
  assign w_spd_chg  = (speed != r_speed_q);
  // A restart edge swallows any coincident tick.
  assign w_tick     = run && (r_cnt == w_term) && !w_mode_chg && !w_spd_chg;

  always_comb begin
    w_start_q = '0;
    case (w_mode)
      M_BOUNCE: w_start_q = ONE_HOT0;
      M_ACCUM:  w_start_q = {1'b1, {(N_LEDS-1){1'b0}}};
      default:  w_start_q = '0;
    endcase
  end

  always_comb begin
    w_nxt_q   = r_q;
    w_nxt_pos = r_pos;
    w_nxt_dir = r_dir;
    w_nxt_k   = r_k;
    w_nxt_p   = r_p;
    case (r_mode_q)
      M_BLINK: w_nxt_q = ~r_q;
      M_FILL:  w_nxt_q = (r_q == ALL_ONES) ? '0 : ((r_q << 1) | ONE_HOT0);
      M_BOUNCE: begin
        if (r_dir) begin
          w_nxt_pos = r_pos + PW'(1);
          w_nxt_dir = (w_nxt_pos != P_TOP);
        end else begin
          w_nxt_pos = r_pos - PW'(1);
          w_nxt_dir = (w_nxt_pos == '0);
        end
        w_nxt_q = ONE_HOT0 << w_nxt_pos;
      end
      M_ACCUM: begin
        if (r_k == K_FULL) begin
          w_nxt_k = '0;
          w_nxt_p = P_TOP;
        end else if (KW'(r_p) > r_k) begin
          w_nxt_p = r_p - PW'(1);
        end else begin
          w_nxt_k = r_k + KW'(1);
          w_nxt_p = P_TOP;
        end
        // Stacked bits below the runner; the full stack shows as all-ones.
        w_nxt_q = (w_nxt_k == K_FULL) ? ALL_ONES
                : (((ONE_HOT0 << w_nxt_k) - ONE_HOT0) | (ONE_HOT0 << w_nxt_p));
      end
      default: w_nxt_q = r_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_mode_q  <= M_BLINK;
      r_speed_q <= '0;
      r_q       <= '0;
      r_step    <= 1'b0;
      r_pos     <= '0;
      r_dir     <= 1'b1;
      r_k       <= '0;
      r_p       <= P_TOP;
    end else begin
      r_mode_q  <= w_mode;
      r_speed_q <= speed;
      r_step    <= w_tick;
      if (w_mode_chg) begin
        r_cnt <= '0;
        r_q   <= w_start_q;
        r_pos <= '0;
        r_dir <= 1'b1;
        r_k   <= '0;
        r_p   <= P_TOP;
      end else if (w_spd_chg) begin
        r_cnt <= '0;
      end else if (run) begin
        if (w_tick) begin
          r_cnt <= '0;
          r_q   <= w_nxt_q;
          r_pos <= w_nxt_pos;
          r_dir <= w_nxt_dir;
          r_k   <= w_nxt_k;
          r_p   <= w_nxt_p;
        end else begin
          r_cnt <= r_cnt + DIV_W'(1);
        end
      end
    end
  end

  assign q_out     = r_q;
  assign step_tick = r_step;

endmodule

// File: tb/tb_led_effect_engine.sv
// Directed bench for led_effect_engine with N_LEDS=8, BASE_DIV=4.
module tb_led_effect_engine;

  logic       clk;
  logic       reset;
  logic [1:0] speed;
  logic [1:0] mode;
  logic       run;
  logic [7:0] q_out;
  logic       step_tick;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  led_effect_engine #(.N_LEDS(8), .BASE_DIV(4), .DIV_W(24)) dut (
    .clk       (clk),
    .reset     (reset),
    .speed     (speed),
    .mode      (mode),
    .run       (run),
    .q_out     (q_out),
    .step_tick (step_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance until step_tick is seen, returning the number of edges waited (bounded).
  task automatic next_tick(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!step_tick && n < 300);
    chk("tick_seen", {31'd0, step_tick}, 32'd1);
  endtask

  task automatic edges(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
    end
  endtask

  logic [7:0] fill_tab   [10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01};
  logic [7:0] bounce_tab [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                  8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] accum_tab  [8]  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h81};

  initial begin
    int n;
    logic saw_step;

    reset = 1'b1; speed = 2'd0; mode = 2'd0; run = 1'b1;
    edges(2);
    chk("reset_q", q_out, 8'h00);
    chk("reset_step", step_tick, 0);
    reset = 1'b0;

    // Blink at speed 0: first all-ones after 4 edges.
    next_tick(n); chk("first_tick_gap", n, 4); chk("blink_t1", q_out, 8'hFF);
    edges(1);      chk("step_one_cycle", step_tick, 0);
    next_tick(n); chk("blink_gap2", n, 3); chk("blink_t2", q_out, 8'h00);
    next_tick(n); chk("blink_gap3", n, 4); chk("blink_t3", q_out, 8'hFF);

    // Speed scaling: first gap includes the restart edge.
    speed = 2'd1;
    next_tick(n); chk("spd1_first", n, 9);  chk("spd1_q1", q_out, 8'h00);
    next_tick(n); chk("spd1_gap", n, 8);    chk("spd1_q2", q_out, 8'hFF);
    speed = 2'd2;
    next_tick(n); chk("spd2_first", n, 17);
    next_tick(n); chk("spd2_gap", n, 16);   chk("spd2_q", q_out, 8'hFF);
    speed = 2'd3;
    next_tick(n); chk("spd3_first", n, 33);
    next_tick(n); chk("spd3_gap", n, 32);   chk("spd3_q", q_out, 8'hFF);
    speed = 2'd0;
    next_tick(n); chk("spd0_first", n, 5);  chk("spd0_q", q_out, 8'h00);

    // Speed change mid-count restarts the prescaler without touching the pattern.
    edges(2);
    speed = 2'd1;
    edges(1); chk("midspd_q_hold", q_out, 8'h00); chk("midspd_no_step", step_tick, 0);
    next_tick(n); chk("midspd_gap", n, 8); chk("midspd_q", q_out, 8'hFF);
    speed = 2'd0;
    next_tick(n); chk("back_spd0_gap", n, 5); chk("back_spd0_q", q_out, 8'h00);

    // FILL.
    mode = 2'd1;
    edges(1); chk("fill_start", q_out, 8'h00); chk("fill_start_step", step_tick, 0);
    for (int i = 0; i < 10; i++) begin
      next_tick(n);
      chk($sformatf("fill_t%0d", i + 1), q_out, fill_tab[i]);
      if (i == 0) chk("fill_first_gap", n, 4);
    end
    next_tick(n); chk("fill_t11", q_out, 8'h03);

    // Mode change coincident with a tick: start pattern wins, no step.
    edges(3);
    mode = 2'd2;
    edges(1); chk("coinc_q", q_out, 8'h01); chk("coinc_step", step_tick, 0);

    // BOUNCE.
    for (int i = 0; i < 15; i++) begin
      next_tick(n);
      chk($sformatf("bounce_t%0d", i + 1), q_out, bounce_tab[i]);
      if (i == 0) chk("bounce_first_gap", n, 4);
    end

    // Pause mid-count: pattern, prescaler and step_tick frozen.
    edges(2);
    run = 1'b0;
    saw_step = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      saw_step = saw_step | step_tick;
    end
    chk("pause_no_step", saw_step, 0);
    chk("pause_hold_q", q_out, 8'h02);
    run = 1'b1;
    next_tick(n); chk("resume_gap", n, 2); chk("resume_q", q_out, 8'h04);

    // Mode change while paused.
    run = 1'b0;
    mode = 2'd3;
    edges(1); chk("paused_mode_q", q_out, 8'h80); chk("paused_mode_step", step_tick, 0);
    edges(5); chk("paused_hold_q", q_out, 8'h80);
    run = 1'b1;

    // ACCUM: 37 ticks per period, all-ones at ticks 35 and 36.
    for (int t = 1; t <= 37; t++) begin
      next_tick(n);
      if (t == 1) chk("accum_first_gap", n, 4);
      if (t <= 8) chk($sformatf("accum_t%0d", t), q_out, accum_tab[t-1]);
      else if (t == 9)  chk("accum_t9", q_out, 8'h41);
      else if (t == 15) chk("accum_t15", q_out, 8'h83);
      else if (t == 35) chk("accum_t35", q_out, 8'hFF);
      else if (t == 36) chk("accum_t36", q_out, 8'hFF);
      else if (t == 37) chk("accum_t37", q_out, 8'h80);
    end

    // Asynchronous reset between clock edges.
    edges(2);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_q", q_out, 8'h00);
    chk("async_rst_step", step_tick, 0);
    mode = 2'd0; speed = 2'd0; run = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    next_tick(n); chk("post_rst_gap", n, 4); chk("post_rst_q", q_out, 8'hFF);
    edges(1); chk("post_rst_step_clear", step_tick, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/led_effect_engine.md
Name: led_effect_engine

Overview:
- Parametrised LED pattern generator for an N-LED bar. Combines a programmable tick prescaler with four selectable animation modes: blink, fill, bounce and stacking accumulate.
- Adds run/pause, clean restart on mode or speed change, and a step strobe.
- Sits between the board switches and the LED pins. Switch inputs are already debounced/synchronised upstream.

Parameters:
- N_LEDS, 8, number of LED outputs; legal range 2..32.
- BASE_DIV, 4, tick period in clk cycles at speed=0; legal minimum 2. Board build overrides to 2**20.
- DIV_W, 24, prescaler counter width; must hold (BASE_DIV<<3)-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- speed  input  2  tick period select: period = BASE_DIV << speed clk cycles.
- mode  input  2  0=BLINK, 1=FILL, 2=BOUNCE, 3=ACCUM.
- run  input  1  1=animate, 0=freeze pattern and prescaler.
- q_out  output  N_LEDS  LED drive, bit 0 = rightmost LED, registered.
- step_tick  output  1  one-cycle pulse in the cycle after every q_out pattern advance, registered.

Behaviour:
- Reset (async, active-high) clears all state immediately:
  - q_out=0, step_tick=0, prescaler cnt=0, mode_q=0, speed_q=0.
  - All pattern state at mode-0 start values: blink phase 0, fill count 0, bounce pos 0 / dir up, accum k=0 / p=N_LEDS-1.
- Prescaler:
  - term = (BASE_DIV<<speed_q)-1.
  - If run=1: cnt increments each clk; at cnt==term it wraps to 0 and asserts internal tick for that cycle.
  - If run=0: cnt holds, no tick is generated, q_out holds.
- Restart:
  - Each cycle, mode_q<=mode and speed_q<=speed.
  - If mode!=mode_q, on that edge: cnt<=0, the pattern state of the newly selected mode is loaded with its start value, and q_out<=that start pattern.
  - If only speed!=speed_q: cnt<=0, pattern is untouched.
  - Restart takes priority over a coincident tick; no pattern advance and no step_tick occur on a restart edge.
  - Restart applies even when run=0.
- Pattern advance: on a tick edge, q_out<=next pattern. step_tick is 1 exactly during the following cycle.
- BLINK:
  - Start: q=0.
  - Each tick toggles q between all-zeros and all-ones. Period 2 ticks.
- FILL:
  - Start: q=0.
  - Each tick: q<=(q<<1)|1 until all-ones; the tick after all-ones gives q=0.
  - Period N_LEDS+1 ticks.
- BOUNCE:
  - Start: q=1 (pos 0), dir up.
  - Each tick pos moves one step in dir. Dir reverses when pos reaches N_LEDS-1 or 0; end LEDs are lit for one tick only.
  - Sequence for N=8: pos 0,1,...,7,6,...,1,0,1,... Period 2*N_LEDS-2 ticks.
- ACCUM:
  - State k (stacked count, 0..N_LEDS) and p (runner position).
  - Start: k=0, p=N_LEDS-1.
  - Output: if k<N_LEDS, q=((1<<k)-1)|(1<<p); if k==N_LEDS, q=all-ones.
  - Tick:
    - If k==N_LEDS: k<=0, p<=N_LEDS-1.
    - Else if p>k: p<=p-1.
    - Else (p==k): k<=k+1, p<=N_LEDS-1.
  - Period N(N+1)/2+1 ticks; 37 for N=8.
- Width rules:
  - All shifts are truncated to N_LEDS bits.
  - k is ceil(log2(N_LEDS+1)) bits wide and p is ceil(log2(N_LEDS)) bits wide.
  - No arithmetic overflow is permitted.
- Pattern state of non-selected modes is don't-care. Only the selected mode's state is defined.

Test Plan:
- Reset mid-animation: assert reset asynchronously between clk edges -> q_out=0 and step_tick=0 immediately. After release with mode=0, speed=0, run=1: first q_out=all-ones after 4 clk cycles, step_tick pulses the next cycle.
- Speed scaling with speed=0..3: step_tick spacing = 4, 8, 16, 32 clk. Changing speed mid-count restarts the prescaler: next tick comes a full period after the change, pattern unchanged.
- FILL with N=8: tick sequence 00,01,03,07,0F,1F,3F,7F,FF,00 (hex), then repeats.
- BOUNCE with N=8: 14 ticks produce 01,02,04,...,80,40,...,02, then 01. 0x80 and 0x01 each held for one tick only.
- ACCUM with N=8: ticks 0..7 give 80,40,...,01; tick 8 gives 81; exactly 37 ticks return q_out to 0x80 with an all-ones (FF) state just before.
- Pause/mode change: run=0 for 100 clk -> q_out and prescaler frozen, no step_tick. Switch mode 2->3 while paused -> q_out=0x80 on the next edge with no step_tick. Mode change coincident with a tick -> start pattern wins and step_tick stays 0.
